// File: rtl/spi_word_arbiter.sv
// ---------------------------------------------------------------------------
// spi_word_arbiter
//
// Round-robin arbiter that shares one SPI word serializer between NUM_REQ
// client blocks. It latches the winning request word, issues a one-cycle
// start to the shift engine, waits for the engine's done pulse, returns a
// one-cycle ack to the owner, and then holds off for GAP_CYCLES clocks so
// chip-select gets a guaranteed high time before the next word.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset (shared with the engine)
//   req          per-requester request level, held until ack
//   req_data     requester i word at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse, requester i transaction finished
//   grant_id     index of the current/last granted requester
//   busy         high whenever the arbiter is not idle
//   eng_start    one-cycle start pulse to the SPI engine
//   eng_data     word for the engine, stable from eng_start until eng_done
//   eng_done     one-cycle pulse from the engine, only honoured while waiting
//   timeout_err  sticky watchdog flag
//
// Build option
//   SPI_ARB_TIMEOUT_EN  when defined, a watchdog completes a transfer whose
//                       engine stays silent for TIMEOUT_CYCLES clocks and sets
//                       timeout_err. When undefined the arbiter waits forever
//                       and timeout_err is tied low.
// ---------------------------------------------------------------------------
module spi_word_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [NUM_REQ-1:0]                             req,
  input  logic [NUM_REQ*DATA_W-1:0]                      req_data,
  output logic [NUM_REQ-1:0]                             ack,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                           busy,
  output logic                                           eng_start,
  output logic [DATA_W-1:0]                              eng_data,
  input  logic                                           eng_done,
  output logic                                           timeout_err
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_M1 = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [7:0]          gap_cnt_r;

  logic [NUM_REQ-1:0]  eff_req_s;
  logic                found_s;
  logic                hit_s;
  logic [ID_W-1:0]     winner_s;
  logic [DATA_W-1:0]   win_data_s;
  logic [NUM_REQ-1:0]  grant_oh_s;
  logic [ID_W-1:0]     ptr_nxt_s;
  logic                expire_s;

  // Round-robin search: scan priority distance k = 0.. from the pointer and
  // take the first requester found. The requester acked this very cycle is
  // masked so it cannot be re-served while its req is still dropping.
  always_comb begin
    eff_req_s = req & ~ack;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    winner_s  = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s    = !found_s && eff_req_s[i] &&
                   (ptr_r == ID_W'((i - k + NUM_REQ) % NUM_REQ));
        found_s  = found_s | hit_s;
        winner_s = hit_s ? ID_W'(i) : winner_s;
      end
    end
  end

  // Word of the winning requester.
  always_comb begin
    win_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = (winner_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : win_data_s;
    end
  end

  // One-hot ack pattern for the current owner and the post-service pointer.
  always_comb begin
    grant_oh_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh_s[i] = (grant_id == ID_W'(i));
    end
    if (grant_id == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = {ID_W{1'b0}};
    end else begin
      ptr_nxt_s = grant_id + ID_W'(1);
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WD_W-1:0] wdog_cnt_r;
  logic            timeout_err_r;

  // Watchdog expiry; an engine done in the same cycle takes precedence.
  always_comb begin
    if ((state_r == S_WAIT) && !eng_done &&
        (wdog_cnt_r == WD_W'(TIMEOUT_CYCLES - 1))) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Watchdog counter (clocks spent in WAIT since eng_start) and sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_r    <= {WD_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (state_r == S_WAIT) begin
      wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
      if (expire_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end else begin
      wdog_cnt_r    <= {WD_W{1'b0}};
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign expire_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      ptr_r     <= {ID_W{1'b0}};
      gap_cnt_r <= 8'd0;
      ack       <= {NUM_REQ{1'b0}};
      grant_id  <= {ID_W{1'b0}};
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_data  <= {DATA_W{1'b0}};
    end else begin
      eng_start <= 1'b0;
      ack       <= {NUM_REQ{1'b0}};
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            eng_start <= 1'b1;
            eng_data  <= win_data_s;
            grant_id  <= winner_s;
            state_r   <= S_WAIT;
            busy      <= 1'b1;
          end else begin
            state_r   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (eng_done || expire_s) begin
            ack   <= grant_oh_s;
            ptr_r <= ptr_nxt_s;
            if (GAP_CYCLES == 0) begin
              state_r   <= S_IDLE;
              busy      <= 1'b0;
              gap_cnt_r <= 8'd0;
            end else begin
              state_r   <= S_GAP;
              busy      <= 1'b1;
              gap_cnt_r <= 8'(GAP_M1);
            end
          end else begin
            state_r <= S_WAIT;
            busy    <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_r == 8'd0) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
            state_r   <= S_GAP;
            busy      <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
